mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LAT, default 1, memory read latency in cycles after the ISSUE edge; legal range 1..3.
REQ-002 clock  input  1  system clock, all state on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 if_req  input  1  instruction-fetch read request, held until if_ack.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_rdata  output  32  fetch read data, registered.
REQ-007 if_ack  output  1  one-cycle fetch completion pulse.
REQ-008 d_req  input  1  data-port request, held until d_ack.
REQ-009 d_we  input  1  data-port write enable (1 = store, 0 = load).
REQ-010 d_addr  input  32  data byte address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_rdata  output  32  load data, registered.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 mem_addr  output  32  address to the single-port memory.
REQ-015 mem_wdata  output  32  write data to memory.
REQ-016 mem_we  output  1  memory write strobe.
REQ-017 mem_rdata  input  32  memory read data.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 State  output  2  current FSM state encoding, for debug visibility.

Function
REQ-020 FSM states SHALL be IDLE=0, ISSUE=1, WAIT=2, DONE=3.
REQ-021 IDLE: no request -> stay; one request -> grant it; both -> grant the port not granted last (last_owner), then last_owner updates to the granted port.
REQ-022 On grant, the arbiter SHALL latch owner, address (bits [1:0] forced to 0), d_we (0 for fetch) and d_wdata into internal registers and go to ISSUE.
REQ-023 ISSUE: mem_addr = latched address; mem_we = 1 only for a data write; write -> DONE, read -> WAIT with latency counter loaded to LAT-1.
REQ-024 WAIT: mem_addr held; counter decrements each cycle; when counter = 0, mem_rdata SHALL be captured into the owner's rdata register and state -> DONE.
REQ-025 DONE: owner's ack = 1 for exactly this cycle; state -> IDLE.
REQ-026 Latency, request seen in IDLE at cycle t: write ack at t+2; read ack at t+LAT+2; rdata valid from the ack cycle.
REQ-027 Each rdata register SHALL hold its value until that port's next read completes; a write SHALL NOT modify d_rdata.
REQ-028 mem_we SHALL be 0 in every state except ISSUE-with-write; mem_wdata SHALL equal the latched write data at all times.
REQ-029 Outside ISSUE/WAIT, mem_addr SHALL keep the last latched address.
REQ-030 A request deasserted after grant SHALL NOT abort the transaction; it completes and acks.
REQ-031 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-032 Never both acks in the same cycle; at most one transaction in flight.

Reset
REQ-033 Reset SHALL immediately force state IDLE, mem_we 0, both acks 0, busy 0, counter 0, all address/data registers 0, last_owner = fetch (so the first conflict goes to the data port).
REQ-034 Reset mid-transaction SHALL abort it with no ack issued.

Structure
REQ-035 A shared package SHALL hold the state enum (2-bit) and the owner enum (OWN_IF, OWN_D).
REQ-036 Single module; no sub-module required.

Verification
REQ-037 if_req only, if_addr=0x00000004, LAT=1, mem_rdata=0x8C220000 -> if_ack at t+3, if_rdata=0x8C220000, mem_we never 1.
REQ-038 d_req, d_we=1, d_addr=0x00000103, d_wdata=0xDEADBEEF -> one mem_we pulse with mem_addr=0x00000100, mem_wdata=0xDEADBEEF; d_ack at t+2; d_rdata unchanged.
REQ-039 if_req and d_req together from reset, held -> data served first, fetch next, alternating thereafter; acks never coincide.
REQ-040 LAT=3, d_req load at 0x20, mem_rdata=0x12345678 on capture cycle -> d_ack at t+5, d_rdata=0x12345678.
REQ-041 reset asserted during WAIT of a read -> state IDLE, busy 0 same cycle, no ack, if_rdata=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port (fetch/data) single-port memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int          CNT_W     = 2;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-port memory; one transaction in flight, round-robin on conflict.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  State
);

  state_t             r_state;
  owner_t             r_owner;
  owner_t             r_last_owner;
  logic [31:0]        r_addr;
  logic               r_we;
  logic [31:0]        r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_d_rdata;

  state_t             w_next_state;
  logic               w_grant;
  owner_t             w_grant_owner;
  logic [31:0]        w_grant_addr;
  logic               w_grant_we;

  // NOTE: every signal written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_grant       = 1'b0;
    w_grant_owner = OWN_IF;
    case (r_state)
      ST_IDLE: begin
        if (if_req && d_req) begin
          w_grant       = 1'b1;
          w_grant_owner = (r_last_owner == OWN_IF) ? OWN_D : OWN_IF;
        end else if (d_req) begin
          w_grant       = 1'b1;
          w_grant_owner = OWN_D;
        end else if (if_req) begin
          w_grant       = 1'b1;
          w_grant_owner = OWN_IF;
        end
        if (w_grant) w_next_state = ST_ISSUE;
      end
      ST_ISSUE: w_next_state = r_we ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (r_cnt == '0) w_next_state = ST_DONE;
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  assign w_grant_addr = (w_grant_owner == OWN_D) ? d_addr : if_addr;
  assign w_grant_we   = (w_grant_owner == OWN_D) && d_we;

  // NOTE: state is updated with non-blocking assignments and an
  // asynchronous reset, so reset takes effect without waiting for a clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_owner      <= OWN_IF;
      r_last_owner <= OWN_IF;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
    end else begin
      if (w_grant) begin
        r_owner      <= w_grant_owner;
        r_last_owner <= w_grant_owner;
        r_addr       <= w_grant_addr & WORD_MASK;
        r_we         <= w_grant_we;
        r_wdata      <= d_wdata;
      end
      if (r_state == ST_ISSUE && !r_we) r_cnt <= CNT_W'(LAT - 1);
      if (r_state == ST_WAIT) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else if (r_owner == OWN_IF) begin
          r_if_rdata <= mem_rdata;
        end else begin
          r_d_rdata  <= mem_rdata;
        end
      end
    end
  end

  // Address and write data stay on the bus between transactions.
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_we    = (r_state == ST_ISSUE) && r_we;
  assign if_ack    = (r_state == ST_DONE) && (r_owner == OWN_IF);
  assign d_ack     = (r_state == ST_DONE) && (r_owner == OWN_D);
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != ST_IDLE);
  assign State     = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench: two arbiters (LAT=1 and LAT=3) against a
// transaction-level model of grant order, ack timing and read data.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock;
  logic        reset     [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic [31:0] if_rdata  [2];
  logic        if_ack    [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic [31:0] d_rdata   [2];
  logic        d_ack     [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic        mem_we    [2];
  logic [31:0] mem_rdata [2];
  logic        busy      [2];
  logic [1:0]  state_o   [2];

  int checks   = 0;
  int failures = 0;

  owner_t      last_own  [2];
  logic [31:0] exp_if_rd [2];
  logic [31:0] exp_d_rd  [2];
  logic [31:0] last_addr [2];
  logic [31:0] ovr [logic [31:0]];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter #(.LAT(1)) u_dut_l1 (
    .clock(clock), .reset(reset[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_ack(if_ack[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ack(d_ack[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .State(state_o[0])
  );

  mem_arbiter #(.LAT(3)) u_dut_l3 (
    .clock(clock), .reset(reset[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_ack(if_ack[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ack(d_ack[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .State(state_o[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (ovr.exists(a)) return ovr[a];
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  // Memory: data for a read issued in ISSUE is valid only in the cycle
  // exactly LAT cycles later; every other cycle returns random junk.
  int          age   [2] = '{100, 100};
  logic [31:0] raddr [2];
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (state_o[k] == ST_ISSUE && !mem_we[k]) begin
        age[k]   = 0;
        raddr[k] = mem_addr[k];
      end else if (age[k] < 100) begin
        age[k]++;
      end
      mem_rdata[k] = (age[k] == lat_of(k)) ? mem_val(raddr[k]) : $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input int k, input string tag);
    check($sformatf("%s k%0d state", tag, k), 32'(state_o[k]), 32'(ST_IDLE));
    check($sformatf("%s k%0d busy", tag, k), 32'(busy[k]), 32'd0);
    check($sformatf("%s k%0d if_ack", tag, k), 32'(if_ack[k]), 32'd0);
    check($sformatf("%s k%0d d_ack", tag, k), 32'(d_ack[k]), 32'd0);
    check($sformatf("%s k%0d mem_we", tag, k), 32'(mem_we[k]), 32'd0);
    check($sformatf("%s k%0d mem_addr", tag, k), mem_addr[k], last_addr[k]);
    check($sformatf("%s k%0d if_rdata", tag, k), if_rdata[k], exp_if_rd[k]);
    check($sformatf("%s k%0d d_rdata", tag, k), d_rdata[k], exp_d_rd[k]);
  endtask

  task automatic do_reset(input int k);
    reset[k]  = 1'b1;
    if_req[k] = 1'b0;
    d_req[k]  = 1'b0;
    d_we[k]   = 1'b0;
    if_addr[k] = '0;
    d_addr[k]  = '0;
    d_wdata[k] = '0;
    @(negedge clock);
    last_own[k]  = OWN_IF;
    exp_if_rd[k] = '0;
    exp_d_rd[k]  = '0;
    last_addr[k] = '0;
    idle_check(k, "reset");
    check($sformatf("reset k%0d mem_wdata", k), mem_wdata[k], 32'd0);
    reset[k] = 1'b0;
  endtask

  task automatic set_if(input int k, input logic [31:0] a);
    if_req[k]  = 1'b1;
    if_addr[k] = a;
  endtask

  task automatic set_d(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd);
    d_req[k]   = 1'b1;
    d_we[k]    = we;
    d_addr[k]  = a;
    d_wdata[k] = wd;
  endtask

  task automatic drop(input int k, input owner_t p);
    if (p == OWN_IF) if_req[k] = 1'b0;
    else             d_req[k]  = 1'b0;
  endtask

  // One granted transaction, starting at the negedge of the IDLE cycle in
  // which the request is visible, ending at the negedge of the next IDLE.
  task automatic serve(input int k, input owner_t p, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit drop_early, input bit hold);
    int          n_ack;
    int          exp_st;
    logic [31:0] a;
    n_ack = we ? 2 : lat_of(k) + 2;
    a     = addr & 32'hFFFF_FFFC;
    for (int n = 1; n <= n_ack; n++) begin
      @(negedge clock);
      exp_st = (n == n_ack) ? 3 : ((n == 1) ? 1 : 2);
      check($sformatf("k%0d c%0d state", k, n), 32'(state_o[k]), 32'(exp_st));
      check($sformatf("k%0d c%0d busy", k, n), 32'(busy[k]), 32'd1);
      check($sformatf("k%0d c%0d if_ack", k, n), 32'(if_ack[k]), 32'(p == OWN_IF && n == n_ack));
      check($sformatf("k%0d c%0d d_ack", k, n), 32'(d_ack[k]), 32'(p == OWN_D && n == n_ack));
      check($sformatf("k%0d c%0d mem_we", k, n), 32'(mem_we[k]), 32'(we && n == 1));
      if (n < n_ack) check($sformatf("k%0d c%0d mem_addr", k, n), mem_addr[k], a);
      if (we && n == 1) check($sformatf("k%0d mem_wdata", k), mem_wdata[k], wdata);
      if (n == n_ack) begin
        if (p == OWN_IF)  exp_if_rd[k] = mem_val(a);
        else if (!we)     exp_d_rd[k]  = mem_val(a);
        check($sformatf("k%0d ack if_rdata", k), if_rdata[k], exp_if_rd[k]);
        check($sformatf("k%0d ack d_rdata", k), d_rdata[k], exp_d_rd[k]);
        if (!hold) drop(k, p);
      end else if (n == 1 && drop_early) begin
        drop(k, p);
      end
    end
    last_own[k]  = p;
    last_addr[k] = a;
    @(negedge clock);
    idle_check(k, "post");
  endtask

  task automatic pair(input int k, input bit iv, input bit dv, input logic we,
                      input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dw,
                      input bit de);
    owner_t first;
    if (iv) set_if(k, ia);
    if (dv) set_d(k, we, da, dw);
    if (iv && dv) first = (last_own[k] == OWN_IF) ? OWN_D : OWN_IF;
    else          first = dv ? OWN_D : OWN_IF;
    if (first == OWN_D) serve(k, OWN_D, we, da, dw, de, 1'b0);
    else                serve(k, OWN_IF, 1'b0, ia, 32'd0, de, 1'b0);
    if (iv && dv) begin
      if (first == OWN_D) serve(k, OWN_IF, 1'b0, ia, 32'd0, de, 1'b0);
      else                serve(k, OWN_D, we, da, dw, de, 1'b0);
    end
  endtask

  initial begin
    int          k;
    bit          iv, dv, we, de;
    logic [31:0] ia, da, dw;
    owner_t      p;

    reset[0] = 1'b1;
    reset[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; d_req[i] = 1'b0; d_we[i] = 1'b0;
      if_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
    end
    do_reset(0);
    do_reset(1);

    // Both ports held from reset: data first, then strict alternation.
    set_if(0, 32'h0000_0040);
    set_d(0, 1'b1, 32'h0000_0081, 32'hCAFE_0001);
    for (int i = 0; i < 4; i++) begin
      p = (last_own[0] == OWN_IF) ? OWN_D : OWN_IF;
      if (p == OWN_D) serve(0, OWN_D, 1'b1, 32'h0000_0081, 32'hCAFE_0001, 1'b0, 1'b1);
      else            serve(0, OWN_IF, 1'b0, 32'h0000_0040, 32'd0, 1'b0, 1'b1);
    end
    if_req[0] = 1'b0;
    d_req[0]  = 1'b0;

    // Single fetch, LAT=1.
    ovr[32'h0000_0004] = 32'h8C22_0000;
    set_if(0, 32'h0000_0004);
    serve(0, OWN_IF, 1'b0, 32'h0000_0004, 32'd0, 1'b0, 1'b0);
    check("fetch4 if_rdata", if_rdata[0], 32'h8C22_0000);

    // Unaligned store: word-aligned address, d_rdata untouched.
    set_d(0, 1'b1, 32'h0000_0103, 32'hDEAD_BEEF);
    serve(0, OWN_D, 1'b1, 32'h0000_0103, 32'hDEAD_BEEF, 1'b0, 1'b0);
    check("store mem_wdata", mem_wdata[0], 32'hDEAD_BEEF);

    // Load with LAT=3.
    ovr[32'h0000_0020] = 32'h1234_5678;
    set_d(1, 1'b0, 32'h0000_0020, 32'h0BAD_F00D);
    serve(1, OWN_D, 1'b0, 32'h0000_0020, 32'h0BAD_F00D, 1'b0, 1'b0);
    check("load20 d_rdata", d_rdata[1], 32'h1234_5678);

    // Fetch whose request drops right after grant still completes.
    set_if(1, 32'h0000_0208);
    serve(1, OWN_IF, 1'b0, 32'h0000_0208, 32'd0, 1'b1, 1'b0);

    // Reset during WAIT aborts the read with no ack.
    set_if(1, 32'h0000_0300);
    @(negedge clock);
    check("abort issue state", 32'(state_o[1]), 32'(ST_ISSUE));
    @(negedge clock);
    check("abort wait state", 32'(state_o[1]), 32'(ST_WAIT));
    reset[1] = 1'b1;
    #1;
    check("abort state", 32'(state_o[1]), 32'(ST_IDLE));
    check("abort busy", 32'(busy[1]), 32'd0);
    check("abort if_ack", 32'(if_ack[1]), 32'd0);
    check("abort d_ack", 32'(d_ack[1]), 32'd0);
    check("abort mem_we", 32'(mem_we[1]), 32'd0);
    check("abort if_rdata", if_rdata[1], 32'd0);
    if_req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("abort no if_ack", 32'(if_ack[1]), 32'd0);
      check("abort no d_ack", 32'(d_ack[1]), 32'd0);
    end
    reset[1] = 1'b0;
    last_own[1]  = OWN_IF;
    exp_if_rd[1] = '0;
    exp_d_rd[1]  = '0;
    last_addr[1] = '0;

    // Randomized traffic on both instances.
    for (int it = 0; it < 80; it++) begin
      k  = it % 2;
      iv = 1'($urandom_range(0, 1));
      dv = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      ia = $urandom;
      da = $urandom;
      dw = $urandom;
      if (!iv && !dv) begin
        @(negedge clock);
        idle_check(k, "gap");
      end else begin
        pair(k, iv, dv, we, ia, da, dw, de);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
